// File: rtl/rv32_pipe_pkg.sv
// Shared encodings and the ID/EX control payload for the RV32I pipeline.
package rv32_pipe_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_MEM   = 2'b01;
    localparam logic [1:0] RES_PC4   = 2'b10;
    localparam logic [1:0] RES_AUIPC = 2'b11;

    localparam logic [3:0] ALU_LUI   = 4'b1110;
    localparam logic [3:0] WSTRB_ALL = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] res_src;
        logic       mem_write;
        logic [3:0] alu_control;
        logic       u_s;
        logic       alu_src;
        logic [3:0] wstrb;
        logic [3:0] wstrb_load;
        logic       reg_write;
        logic       pc_in_sel;
        logic       jump;
        logic       branch;
    } ctrl_t;

    // Control word of an inserted bubble: no side effects, full strobes.
    localparam ctrl_t CTRL_BUBBLE = '{
        valid:       1'b0,
        res_src:     RES_ALU,
        mem_write:   1'b0,
        alu_control: 4'b0000,
        u_s:         1'b0,
        alu_src:     1'b0,
        wstrb:       WSTRB_ALL,
        wstrb_load:  WSTRB_ALL,
        reg_write:   1'b0,
        pc_in_sel:   1'b0,
        jump:        1'b0,
        branch:      1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the EX-stage load targets a register the ID instruction reads.
module load_use_detect
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [1:0]        id_res_src_i,
    input  logic [3:0]        id_alu_control_i,
    input  logic              id_jump_i,
    input  logic              id_pc_in_sel_i,
    input  logic              id_alu_src_i,
    input  logic              id_mem_write_i,
    input  logic              id_branch_i,
    input  logic              ex_valid_i,
    input  logic [1:0]        ex_res_src_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    output logic              hazard_c_o
);

    logic use_rs1;
    logic use_rs2;
    logic ex_is_load;

    // JAL, AUIPC and LUI carry no real rs1; I-type ALU ops carry no real rs2.
    assign use_rs1 = !(id_jump_i && !id_pc_in_sel_i)
                   && (id_res_src_i != RES_AUIPC)
                   && (id_alu_control_i != ALU_LUI);
    assign use_rs2 = !id_alu_src_i || id_mem_write_i || id_branch_i;

    assign ex_is_load = ex_valid_i && (ex_res_src_i == RES_MEM) && (ex_rd_i != '0);

    assign hazard_c_o = ex_is_load && id_valid_i
                      && ((use_rs1 && (id_rs1_i == ex_rd_i))
                       || (use_rs2 && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, flush and downstream hold.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        id_res_src,
    input  logic              id_mem_write,
    input  logic [3:0]        id_alu_control,
    input  logic              id_u_s,
    input  logic              id_alu_src,
    input  logic [3:0]        id_wstrb,
    input  logic [3:0]        id_wstrb_load,
    input  logic              id_reg_write,
    input  logic              id_pc_in_sel,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_pc_plus4,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [1:0]        ex_res_src,
    output logic              ex_mem_write,
    output logic [3:0]        ex_alu_control,
    output logic              ex_u_s,
    output logic              ex_alu_src,
    output logic [3:0]        ex_wstrb,
    output logic [3:0]        ex_wstrb_load,
    output logic              ex_reg_write,
    output logic              ex_pc_in_sel,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_pc_plus4,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              stall_if_id
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d, ctrl_q;
    logic              capture;
    logic              hazard;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q, pc_q, pc_plus4_q;

    assign id_ctrl = '{
        valid:       id_valid,
        res_src:     id_res_src,
        mem_write:   id_mem_write,
        alu_control: id_alu_control,
        u_s:         id_u_s,
        alu_src:     id_alu_src,
        wstrb:       id_wstrb,
        wstrb_load:  id_wstrb_load,
        reg_write:   id_reg_write,
        pc_in_sel:   id_pc_in_sel,
        jump:        id_jump,
        branch:      id_branch
    };

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .id_valid_i       (id_valid),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_res_src_i     (id_res_src),
        .id_alu_control_i (id_alu_control),
        .id_jump_i        (id_jump),
        .id_pc_in_sel_i   (id_pc_in_sel),
        .id_alu_src_i     (id_alu_src),
        .id_mem_write_i   (id_mem_write),
        .id_branch_i      (id_branch),
        .ex_valid_i       (ctrl_q.valid),
        .ex_res_src_i     (ctrl_q.res_src),
        .ex_rd_i          (rd_q),
        .hazard_c_o       (hazard)
    );

    // Priority: hold > flush > load-use > capture. Bubbles leave data fields untouched.
    always_comb begin
        ctrl_d      = ctrl_q;
        capture     = 1'b0;
        stall_if_id = 1'b0;
        if (ex_hold) begin
            stall_if_id = 1'b1;
        end else if (flush) begin
            ctrl_d = CTRL_BUBBLE;
        end else if (hazard) begin
            ctrl_d      = CTRL_BUBBLE;
            stall_if_id = 1'b1;
        end else if (!id_valid) begin
            ctrl_d = CTRL_BUBBLE;
        end else begin
            ctrl_d  = id_ctrl;
            capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            if (capture) begin
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                pc_q       <= id_pc;
                pc_plus4_q <= id_pc_plus4;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    // Counters track which rule won the edge; a held edge counts nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else if (!ex_hold) begin
            if (flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end else if (hazard) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

    assign ex_valid       = ctrl_q.valid;
    assign ex_res_src     = ctrl_q.res_src;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_alu_control = ctrl_q.alu_control;
    assign ex_u_s         = ctrl_q.u_s;
    assign ex_alu_src     = ctrl_q.alu_src;
    assign ex_wstrb       = ctrl_q.wstrb;
    assign ex_wstrb_load  = ctrl_q.wstrb_load;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_pc_in_sel   = ctrl_q.pc_in_sel;
    assign ex_jump        = ctrl_q.jump;
    assign ex_branch      = ctrl_q.branch;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_rd          = rd_q;
    assign ex_rs1_data    = rs1_data_q;
    assign ex_rs2_data    = rs2_data_q;
    assign ex_imm         = imm_q;
    assign ex_pc          = pc_q;
    assign ex_pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; define ID_EX_PERF_CNT_EN to also check the counters.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_mem_write, id_u_s, id_alu_src, id_reg_write;
    logic        id_pc_in_sel, id_jump, id_branch;
    logic [1:0]  id_res_src;
    logic [3:0]  id_alu_control, id_wstrb, id_wstrb_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4;
    logic        flush, ex_hold;
    logic        ex_valid, ex_mem_write, ex_u_s, ex_alu_src, ex_reg_write;
    logic        ex_pc_in_sel, ex_jump, ex_branch;
    logic [1:0]  ex_res_src;
    logic [3:0]  ex_alu_control, ex_wstrb, ex_wstrb_load;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus4;
    logic        stall_if_id;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_res_src(id_res_src), .id_mem_write(id_mem_write),
        .id_alu_control(id_alu_control), .id_u_s(id_u_s), .id_alu_src(id_alu_src),
        .id_wstrb(id_wstrb), .id_wstrb_load(id_wstrb_load), .id_reg_write(id_reg_write),
        .id_pc_in_sel(id_pc_in_sel), .id_jump(id_jump), .id_branch(id_branch),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_res_src(ex_res_src), .ex_mem_write(ex_mem_write),
        .ex_alu_control(ex_alu_control), .ex_u_s(ex_u_s), .ex_alu_src(ex_alu_src),
        .ex_wstrb(ex_wstrb), .ex_wstrb_load(ex_wstrb_load), .ex_reg_write(ex_reg_write),
        .ex_pc_in_sel(ex_pc_in_sel), .ex_jump(ex_jump), .ex_branch(ex_branch),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
`ifdef ID_EX_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .stall_if_id(stall_if_id)
    );

    typedef struct {
        bit        valid;
        bit [1:0]  res_src;
        bit        mem_write;
        bit [3:0]  alu_control;
        bit        u_s;
        bit        alu_src;
        bit [3:0]  wstrb;
        bit [3:0]  wstrb_load;
        bit        reg_write;
        bit        pc_in_sel;
        bit        jump;
        bit        branch;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] rs1_data, rs2_data, imm, pc, pc_plus4;
    } ins_t;

    ins_t        ex_m;
    ins_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit [31:0]   stall_cnt_m = 0;
    bit [31:0]   flush_cnt_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t zero_ins();
        ins_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Plain ALU op with the common fields set; directed cases tweak from here.
    function automatic ins_t alu_op(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
        ins_t i;
        i = zero_ins();
        i.valid = 1; i.reg_write = 1; i.wstrb = 4'hF; i.wstrb_load = 4'hF;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
        i.pc = $urandom; i.pc_plus4 = i.pc + 4;
        return i;
    endfunction

    function automatic ins_t load_op(input bit [4:0] rd);
        ins_t i;
        i = alu_op(5'd1, 5'd0, rd);
        i.res_src = 2'b01; i.alu_src = 1;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.valid       = ($urandom_range(0, 7) != 0);
        i.res_src     = 2'($urandom);
        i.mem_write   = 1'($urandom);
        i.alu_control = 4'($urandom);
        i.u_s         = 1'($urandom);
        i.alu_src     = 1'($urandom);
        i.wstrb       = 4'($urandom);
        i.wstrb_load  = 4'($urandom);
        i.reg_write   = 1'($urandom);
        i.pc_in_sel   = 1'($urandom);
        i.jump        = 1'($urandom);
        i.branch      = 1'($urandom);
        i.rs1         = 5'($urandom_range(0, 3));
        i.rs2         = 5'($urandom_range(0, 3));
        i.rd          = 5'($urandom_range(0, 3));
        i.rs1_data    = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
        i.pc          = $urandom; i.pc_plus4 = $urandom;
        return i;
    endfunction

    // Which source registers an instruction really reads.
    function automatic bit reads_rs1(input ins_t i);
        bit is_jal, is_auipc, is_lui;
        is_jal   = i.jump && !i.pc_in_sel;
        is_auipc = (i.res_src == 2'b11);
        is_lui   = (i.alu_control == 4'b1110);
        return !(is_jal || is_auipc || is_lui);
    endfunction

    function automatic bit reads_rs2(input ins_t i);
        return !i.alu_src || i.mem_write || i.branch;
    endfunction

    function automatic bit load_use(input ins_t ex, input ins_t id);
        if (!(ex.valid && ex.res_src == 2'b01 && ex.rd != 0 && id.valid)) return 0;
        return (reads_rs1(id) && id.rs1 == ex.rd) || (reads_rs2(id) && id.rs2 == ex.rd);
    endfunction

    function automatic ins_t bubble_of(input ins_t cur);
        ins_t b;
        b = cur;
        b.valid = 0; b.res_src = 0; b.mem_write = 0; b.alu_control = 0;
        b.u_s = 0; b.alu_src = 0; b.reg_write = 0; b.pc_in_sel = 0;
        b.jump = 0; b.branch = 0; b.wstrb = 4'hF; b.wstrb_load = 4'hF;
        return b;
    endfunction

    function automatic ins_t sample();
        ins_t s;
        s.valid = ex_valid; s.res_src = ex_res_src; s.mem_write = ex_mem_write;
        s.alu_control = ex_alu_control; s.u_s = ex_u_s; s.alu_src = ex_alu_src;
        s.wstrb = ex_wstrb; s.wstrb_load = ex_wstrb_load; s.reg_write = ex_reg_write;
        s.pc_in_sel = ex_pc_in_sel; s.jump = ex_jump; s.branch = ex_branch;
        s.rs1 = ex_rs1; s.rs2 = ex_rs2; s.rd = ex_rd;
        s.rs1_data = ex_rs1_data; s.rs2_data = ex_rs2_data; s.imm = ex_imm;
        s.pc = ex_pc; s.pc_plus4 = ex_pc_plus4;
        return s;
    endfunction

    // Control always compared; data only when it is defined (valid entry or reset).
    task automatic cmp_ins(input ins_t a, input ins_t e, input bit full);
        chk("ex_valid", 32'(a.valid), 32'(e.valid));
        chk("ex_res_src", 32'(a.res_src), 32'(e.res_src));
        chk("ex_mem_write", 32'(a.mem_write), 32'(e.mem_write));
        chk("ex_alu_control", 32'(a.alu_control), 32'(e.alu_control));
        chk("ex_u_s", 32'(a.u_s), 32'(e.u_s));
        chk("ex_alu_src", 32'(a.alu_src), 32'(e.alu_src));
        chk("ex_wstrb", 32'(a.wstrb), 32'(e.wstrb));
        chk("ex_wstrb_load", 32'(a.wstrb_load), 32'(e.wstrb_load));
        chk("ex_reg_write", 32'(a.reg_write), 32'(e.reg_write));
        chk("ex_pc_in_sel", 32'(a.pc_in_sel), 32'(e.pc_in_sel));
        chk("ex_jump", 32'(a.jump), 32'(e.jump));
        chk("ex_branch", 32'(a.branch), 32'(e.branch));
        if (full || e.valid) begin
            chk("ex_rs1", 32'(a.rs1), 32'(e.rs1));
            chk("ex_rs2", 32'(a.rs2), 32'(e.rs2));
            chk("ex_rd", 32'(a.rd), 32'(e.rd));
            chk("ex_rs1_data", a.rs1_data, e.rs1_data);
            chk("ex_rs2_data", a.rs2_data, e.rs2_data);
            chk("ex_imm", a.imm, e.imm);
            chk("ex_pc", a.pc, e.pc);
            chk("ex_pc_plus4", a.pc_plus4, e.pc_plus4);
        end
    endtask

    task automatic check_perf();
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, stall_cnt_m);
        chk("perf_flush_cnt", perf_flush_cnt, flush_cnt_m);
`endif
    endtask

    // Drive one ID slot between edges, check the stall, queue the expected EX entry.
    task automatic apply(input ins_t id, input bit fl, input bit hd);
        bit   hz, exp_stall;
        ins_t nxt;
        @(negedge clk);
        id_valid = id.valid; id_res_src = id.res_src; id_mem_write = id.mem_write;
        id_alu_control = id.alu_control; id_u_s = id.u_s; id_alu_src = id.alu_src;
        id_wstrb = id.wstrb; id_wstrb_load = id.wstrb_load; id_reg_write = id.reg_write;
        id_pc_in_sel = id.pc_in_sel; id_jump = id.jump; id_branch = id.branch;
        id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        id_rs1_data = id.rs1_data; id_rs2_data = id.rs2_data; id_imm = id.imm;
        id_pc = id.pc; id_pc_plus4 = id.pc_plus4;
        flush = fl; ex_hold = hd;
        hz = load_use(ex_m, id);
        exp_stall = hd || (!fl && hz);
        #1 chk("stall_if_id", 32'(stall_if_id), 32'(exp_stall));
        if (hd) nxt = ex_m;
        else if (fl || hz || !id.valid) nxt = bubble_of(ex_m);
        else nxt = id;
        if (!hd && fl) flush_cnt_m++;
        else if (!hd && hz) stall_cnt_m++;
        exp_q.push_back(nxt);
        ex_m = nxt;
    endtask

    task automatic do_reset_check();
        ex_m = zero_ins();
        exp_q.delete();
        stall_cnt_m = 0;
        flush_cnt_m = 0;
        #1 cmp_ins(sample(), ex_m, 1'b1);
        check_perf();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                ins_t e;
                e = exp_q.pop_front();
                cmp_ins(sample(), e, 1'b0);
            end
        end
    end

    initial begin : stimulus
        ins_t i, ld;
        reset = 1'b0;
        flush = 0; ex_hold = 0;
        id_valid = 0; id_res_src = 0; id_mem_write = 0; id_alu_control = 0; id_u_s = 0;
        id_alu_src = 0; id_wstrb = 0; id_wstrb_load = 0; id_reg_write = 0;
        id_pc_in_sel = 0; id_jump = 0; id_branch = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0; id_pc_plus4 = 0;
        do_reset_check();
        #12;
        @(negedge clk) reset = 1'b1;

        // Reset mid-stream: outputs clear without waiting for a clock edge.
        apply(alu_op(5'd1, 5'd2, 5'd3), 0, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        do_reset_check();
        @(negedge clk) reset = 1'b1;
        apply(alu_op(5'd4, 5'd5, 5'd6), 0, 0);

        // Load-use: one bubble, then the consumer is captured.
        ld = load_op(5'd5);
        apply(ld, 0, 0);
        i = alu_op(5'd5, 5'd7, 5'd8);
        apply(i, 0, 0);
        apply(i, 0, 0);
        @(posedge clk); #2 check_perf();

        // Load to x0 followed by a reader of x0.
        apply(load_op(5'd0), 0, 0);
        apply(alu_op(5'd0, 5'd0, 5'd9), 0, 0);

        // Load followed by LUI whose rs1 field aliases the load target.
        apply(load_op(5'd5), 0, 0);
        i = alu_op(5'd5, 5'd5, 5'd6);
        i.alu_control = 4'b1110; i.alu_src = 1;
        apply(i, 0, 0);

        // Load followed by ADDI whose rs2 field aliases the load target.
        apply(load_op(5'd5), 0, 0);
        i = alu_op(5'd1, 5'd5, 5'd6);
        i.alu_src = 1;
        apply(i, 0, 0);

        // Flush beats a simultaneous load-use.
        apply(load_op(5'd5), 0, 0);
        apply(alu_op(5'd5, 5'd1, 5'd2), 1, 0);

        // Hold freezes EX even with flush asserted; release with flush gives a bubble.
        apply(alu_op(5'd1, 5'd2, 5'd3), 0, 0);
        for (int k = 0; k < 3; k++) apply(alu_op(5'd3, 5'd3, 5'd4), 1, 1);
        apply(alu_op(5'd3, 5'd3, 5'd4), 1, 0);

        // Store pass-through with a halfword strobe.
        i = alu_op(5'd2, 5'd3, 5'd0);
        i.mem_write = 1; i.reg_write = 0; i.alu_src = 1; i.wstrb = 4'b0011;
        i.imm = 32'h7FC; i.pc = 32'h100; i.pc_plus4 = 32'h104;
        apply(i, 0, 0);

        for (int n = 0; n < 400; n++) begin
            bit fl, hd;
            fl = ($urandom_range(0, 7) == 0);
            hd = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) apply(load_op(5'($urandom_range(0, 3))), fl, hd);
            else apply(rand_ins(), fl, hd);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        check_perf();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
